or4_gate: RTL and testbench
===========================

Name: or4_gate

Overview:
- Registered, parameterised-width bitwise OR of two operand vectors (default 4 bits), with a one-cycle valid pipeline.
- Optional sticky-accumulate mode and reduction flags for downstream status/mask logic.
- Sits as a leaf datapath primitive; single clock domain, no backpressure.

Parameters:
- WIDTH, 4, operand/result width in bits (>=1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands a/b valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- acc_en  input  1  accumulate: OR new operands into held result instead of replacing it.
- clr  input  1  synchronous clear of result register.
- y  output  WIDTH  registered result.
- out_valid  output  1  y updated in previous cycle from a valid input.
- y_any  output  1  reduction OR of y.
- y_all  output  1  reduction AND of y.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: y=0, out_valid=0, therefore y_any=0, y_all=0 (y_all=0 even for WIDTH=1 since y=0).
- Priority per rising edge: rst > clr > in_valid > hold.
- clr=1 (rst=0): y<=0, out_valid<=0; concurrent in_valid is dropped.
- in_valid=1, acc_en=0: y<=a|b (bitwise); out_valid<=1.
- in_valid=1, acc_en=1: y<=y|a|b; out_valid<=1.
- in_valid=0: y holds; out_valid<=0. a, b, acc_en are don't-care (X must not propagate into y).
- Latency: exactly 1 cycle from in_valid to out_valid/y; full throughput, one result per cycle.
- y_any, y_all: combinational from registered y, no extra latency.
- No overflow/wrap concerns: pure bitwise, result width = WIDTH.
- Reset asserted mid-stream: following cycle y=0, out_valid=0 regardless of in_valid.

Optional Feature:
- Macro OR4_GATE_COMB_OUT_EN.
- Defined: extra output y_comb (WIDTH) = a|b, purely combinational, independent of in_valid, acc_en, clr, rst; zero latency.
- Undefined: port y_comb absent; registered path unchanged in all cases.

Decomposition:
- Package or4_gate_pkg: localparam OR4_GATE_DEFAULT_WIDTH=4; result zero constant helper.
- No sub-module required; reduction flags kept inline.

Test Plan:
- rst=1 one cycle -> y=0000, out_valid=0, y_any=0, y_all=0.
- in_valid=1, acc_en=0, back-to-back a/b = 0000/0000, 1010/0101, 1111/1010, 1100/0110 -> y each following cycle = 0000, 1111, 1111, 1110; out_valid=1 each; y_all=1 only for the 1111 results.
- Accumulate: a=0001,b=0000 (acc_en=0) then a=0100,b=0000 (acc_en=1) -> y=0001 then 0101; y_any=1, y_all=0.
- Hold: in_valid=0 with a=b=XXXX -> y keeps last value, out_valid=0.
- clr=1 together with in_valid=1, a=1111 -> y=0000, out_valid=0; rst asserted while clr=1 -> same result.
- With OR4_GATE_COMB_OUT_EN: a=1100,b=0110 -> y_comb=1110 same cycle, y=1110 next cycle.

Source files
------------

// File: rtl/or4_gate_pkg.sv
// Shared definitions for the or4_gate registered bitwise-OR primitive.
// Holds the default width, the all-zero result helper and the per-edge
// operation decode used by the result register.
package or4_gate_pkg;

  localparam int OR4_GATE_DEFAULT_WIDTH = 4;

  // One zero bit, replicated to the active width wherever a cleared result is needed.
  localparam logic OR4_GATE_ZERO_BIT = 1'b0;

  // What the result register does on the next rising edge when not in reset.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_LOAD  = 2'd2,
    OP_ACC   = 2'd3
  } or4_gate_op_e;

  // Clear wins over a new operand pair; without valid operands the result holds.
  function automatic or4_gate_op_e decode_op(input logic clr,
                                             input logic in_valid,
                                             input logic acc_en);
    or4_gate_op_e op;
    if (clr) begin
      op = OP_CLEAR;
    end else if (in_valid) begin
      op = acc_en ? OP_ACC : OP_LOAD;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/or4_gate_if.sv
// Operand/result bundle for or4_gate.
// With OR4_GATE_COMB_OUT_EN defined the bundle also carries y_comb, the
// unregistered a|b.
interface or4_gate_if #(
  parameter int WIDTH = or4_gate_pkg::OR4_GATE_DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_en;
  logic             clr;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             y_any;
  logic             y_all;
`ifdef OR4_GATE_COMB_OUT_EN
  logic [WIDTH-1:0] y_comb;
`endif

  // The producer side: drives operands and controls, observes the result.
  modport master (
    output in_valid, a, b, acc_en, clr,
`ifdef OR4_GATE_COMB_OUT_EN
    input  y_comb,
`endif
    input  y, out_valid, y_any, y_all
  );

  // The OR primitive itself.
  modport slave (
    input  in_valid, a, b, acc_en, clr,
`ifdef OR4_GATE_COMB_OUT_EN
    output y_comb,
`endif
    output y, out_valid, y_any, y_all
  );

endinterface

// File: rtl/or4_gate.sv
// or4_gate: registered WIDTH-bit bitwise OR of two operands with a one-cycle
// valid pipeline, optional sticky accumulation and reduction status flags.
// Optional feature macro: OR4_GATE_COMB_OUT_EN adds the combinational y_comb = a|b.
module or4_gate
  import or4_gate_pkg::*;
#(
  parameter int WIDTH = OR4_GATE_DEFAULT_WIDTH
) (
  input logic       clk,
  input logic       rst,
  or4_gate_if.slave bus
);

  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_d;
  logic             out_valid_q;
  logic             out_valid_d;
  or4_gate_op_e     op;

  // Next result and valid from the decoded operation; idle operands never reach y.
  always_comb begin
    op          = decode_op(bus.clr, bus.in_valid, bus.acc_en);
    y_d         = y_q;
    out_valid_d = 1'b0;
    case (op)
      OP_CLEAR: begin
        y_d         = {WIDTH{OR4_GATE_ZERO_BIT}};
        out_valid_d = 1'b0;
      end
      OP_LOAD: begin
        y_d         = bus.a | bus.b;
        out_valid_d = 1'b1;
      end
      OP_ACC: begin
        y_d         = y_q | bus.a | bus.b;
        out_valid_d = 1'b1;
      end
      default: begin
        y_d         = y_q;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Result and valid registers; synchronous reset overrides every other control.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= {WIDTH{OR4_GATE_ZERO_BIT}};
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y_any     = |y_q;
  assign bus.y_all     = &y_q;

`ifdef OR4_GATE_COMB_OUT_EN
  assign bus.y_comb = bus.a | bus.b;
`endif

endmodule

// File: tb/tb_or4_gate.sv
// Directed testbench for or4_gate (WIDTH=4). Expected values are hand-computed
// constants; checks happen 1ns after the rising edge that updates the outputs.
module tb_or4_gate;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  or4_gate_if #(.WIDTH(W)) bus ();

  or4_gate #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs, advance past the next rising edge.
  task automatic applyStimulus(input logic r, input logic c, input logic v,
                               input logic acc, input logic [W-1:0] av,
                               input logic [W-1:0] bv);
    rst          = r;
    bus.clr      = c;
    bus.in_valid = v;
    bus.acc_en   = acc;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point; counts every check and every failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check all registered outputs at once.
  task automatic checkAll(input string tag, input logic [W-1:0] ey,
                          input logic ev, input logic eany, input logic eall);
    checkOutput({tag, ".y"},         32'(bus.y),         32'(ey));
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    checkOutput({tag, ".y_any"},     32'(bus.y_any),     32'(eany));
    checkOutput({tag, ".y_all"},     32'(bus.y_all),     32'(eall));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst          = 1'b1;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.acc_en   = 1'b0;
    bus.a        = '0;
    bus.b        = '0;

    // Reset for one cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    checkAll("reset", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back plain loads.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkAll("load0", 4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0101);
    checkAll("load1", 4'b1111, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b1010);
    checkAll("load2", 4'b1111, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 4'b0110);
    checkAll("load3", 4'b1110, 1'b1, 1'b1, 1'b0);

    // Load replaces (does not accumulate) when acc_en=0.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000);
    checkAll("acc_seed", 4'b0001, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b0100, 4'b0000);
    checkAll("acc_step", 4'b0101, 1'b1, 1'b1, 1'b0);

    // Hold with unknown operands: y keeps its value, out_valid drops.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'bx, 4'bxxxx, 4'bxxxx);
    checkAll("hold0", 4'b0101, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'bx, 4'bxxxx, 4'bxxxx);
    checkAll("hold1", 4'b0101, 1'b0, 1'b1, 1'b0);

    // Accumulate after a hold keeps the sticky bits.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 4'b0000);
    checkAll("acc_after_hold", 4'b1101, 1'b1, 1'b1, 1'b0);

    // Clear beats a concurrent valid input.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000);
    checkAll("clr_vs_valid", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset together with clear and valid.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000);
    checkAll("reload", 4'b1111, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000);
    checkAll("rst_with_clr", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream with valid input.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b0000);
    checkAll("stream", 4'b0011, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111);
    checkAll("rst_midstream", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Accumulate starting from a cleared result.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 4'b0010);
    checkAll("acc_from_zero", 4'b1010, 1'b1, 1'b1, 1'b0);

`ifdef OR4_GATE_COMB_OUT_EN
    // Combinational output follows a|b in the same cycle, ignoring controls.
    rst          = 1'b0;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b1;
    bus.acc_en   = 1'b0;
    bus.a        = 4'b1100;
    bus.b        = 4'b0110;
    #1;
    checkOutput("y_comb_same_cycle", 32'(bus.y_comb), 32'(4'b1110));
    @(posedge clk);
    #1;
    checkOutput("y_after_comb", 32'(bus.y), 32'(4'b1110));
    rst          = 1'b1;
    bus.clr      = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = 4'b0011;
    bus.b        = 4'b0100;
    #1;
    checkOutput("y_comb_in_rst", 32'(bus.y_comb), 32'(4'b0111));
    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.clr = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
